// File: rtl/layer_sequencer_pkg.sv
// ============================================================================
//  Package   : layer_sequencer_pkg
//  Purpose   : Shared types and constants for the inter-layer sequencer.
//  Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

package layer_sequencer_pkg;

    localparam int FRAME_CNT_W = 16;

    typedef enum logic [0:0] {
        SEQ_IDLE = 1'b0,
        SEQ_SEND = 1'b1
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/layer_sequencer_par2ser_buf.sv
// ============================================================================
//  Module    : layer_sequencer_par2ser_buf
//  Purpose   : NN-word parallel-load buffer read back one word at a time.
//  Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

module layer_sequencer_par2ser_buf #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic                    adv_i,
    input  logic [NN*dataWidth-1:0] data_i,
    output logic [dataWidth-1:0]    word_o,
    output logic                    last_o
);

    localparam int IDX_W = $clog2(NN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);

    logic [dataWidth-1:0] mem_q [NN];
    logic [IDX_W-1:0]     idx_q;

    generate
        for (genvar gi = 0; gi < NN; gi++) begin : g_word
            always_ff @(posedge clk) begin
                if (!rst) begin
                    mem_q[gi] <= '0;
                end else if (load_i) begin
                    mem_q[gi] <= data_i[gi*dataWidth +: dataWidth];
                end
            end
        end
    endgenerate

    // Load wins over advance so a back-to-back capture restarts at word 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q <= '0;
        end else if (load_i) begin
            idx_q <= '0;
        end else if (adv_i) begin
            idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    assign word_o = mem_q[idx_q];
    assign last_o = (idx_q == LAST_IDX);

endmodule

`default_nettype wire

// File: rtl/layer_sequencer.sv
// ============================================================================
//  Module    : layer_sequencer
//  Purpose   : Captures a parallel layer output and replays it word-serially
//              to the next layer, with frame counting and error flags.
//  Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int NN        = 30,
    parameter int dataWidth = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           in_valid,
    input  logic [NN*dataWidth-1:0] in_data,
    input  logic                    hold,
    output logic                    out_valid,
    output logic [dataWidth-1:0]    out_data,
    output logic                    busy,
    output logic                    frame_done,
    output logic [FRAME_CNT_W-1:0]  frame_count,
    output logic                    err_overrun,
    output logic                    err_partial
);

    seq_state_t             state_q, state_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic                   err_overrun_q;
    logic                   err_partial_q;

    logic                   w_capture;
    logic                   w_xfer;
    logic                   w_last;
    logic                   w_overrun;
    logic                   w_buf_last;
    logic [dataWidth-1:0]   w_word;

    layer_sequencer_par2ser_buf #(
        .NN        (NN),
        .dataWidth (dataWidth)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .load_i (w_capture),
        .adv_i  (w_xfer),
        .data_i (in_data),
        .word_o (w_word),
        .last_o (w_buf_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= SEQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        w_capture = 1'b0;
        w_xfer    = 1'b0;
        w_last    = 1'b0;
        w_overrun = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (in_valid[0]) begin
                    w_capture = 1'b1;
                    state_d   = SEQ_SEND;
                end
            end
            SEQ_SEND: begin
                w_xfer = !hold;
                w_last = w_xfer && w_buf_last;
                // A new frame is only accepted on the edge that retires the current one.
                if (w_last) begin
                    if (in_valid[0]) begin
                        w_capture = 1'b1;
                    end else begin
                        state_d = SEQ_IDLE;
                    end
                end else if (in_valid[0]) begin
                    w_overrun = 1'b1;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_cnt_q   <= '0;
            err_overrun_q <= 1'b0;
            err_partial_q <= 1'b0;
        end else begin
            if (w_last) begin
                frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
            end
            if (w_overrun) begin
                err_overrun_q <= 1'b1;
            end
            if (w_capture && (in_valid != {NN{1'b1}})) begin
                err_partial_q <= 1'b1;
            end
        end
    end

    assign out_valid   = w_xfer;
    assign out_data    = (state_q == SEQ_SEND) ? w_word : '0;
    assign busy        = (state_q == SEQ_SEND);
    assign frame_done  = w_last && rst;
    assign frame_count = frame_cnt_q;
    assign err_overrun = err_overrun_q;
    assign err_partial = err_partial_q;

endmodule

`default_nettype wire

// File: tb/tb_layer_sequencer.sv
// ============================================================================
//  Module    : tb_layer_sequencer
//  Purpose   : Self-checking bench for layer_sequencer (NN=4, 16-bit words).
//  Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_layer_sequencer;

    localparam int NN = 4;
    localparam int DW = 16;

    logic             clk;
    logic             rst;
    logic [NN-1:0]    in_valid;
    logic [NN*DW-1:0] in_data;
    logic             hold;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic             busy;
    logic             frame_done;
    logic [15:0]      frame_count;
    logic             err_overrun;
    logic             err_partial;

    layer_sequencer #(
        .NN        (NN),
        .dataWidth (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .hold        (hold),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .err_overrun (err_overrun),
        .err_partial (err_partial)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [63:0] FRAME_A = 64'h0004_0003_0002_0001;
    localparam logic [63:0] FRAME_B = 64'h00B4_00B3_00B2_00B1;

    // Model: queue of words still owed downstream for the frame in flight.
    logic [15:0] mq[$];
    logic [15:0] m_count;
    logic        m_ovr;
    logic        m_part;
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            mq.delete();
            m_count  = '0;
            m_ovr    = 1'b0;
            m_part   = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            bit fin;
            fin = 1'b0;
            if (mq.size() > 0 && !hold) begin
                if (mq.size() == 1) begin
                    fin     = 1'b1;
                    m_count = m_count + 16'd1;
                end
                void'(mq.pop_front());
            end
            if (in_valid[0]) begin
                if (mq.size() == 0) begin
                    for (int k = 0; k < NN; k++) mq.push_back(in_data[k*DW +: DW]);
                    if (in_valid != 4'hF) m_part = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end
            if (fin && mq.size() > NN) m_ovr = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            logic        e_busy, e_valid, e_done;
            logic [15:0] e_data;
            logic [36:0] exp_v, act_v;
            e_busy  = (mq.size() > 0);
            e_valid = e_busy && !hold;
            e_data  = e_busy ? mq[0] : 16'h0;
            e_done  = rst && e_valid && (mq.size() == 1);
            exp_v = {e_valid, e_data, e_busy, e_done, m_count, m_ovr, m_part};
            act_v = {out_valid, out_data, busy, frame_done, frame_count, err_overrun, err_partial};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL model t=%0t: got v=%b d=%h busy=%b done=%b cnt=%h ovr=%b part=%b, expected v=%b d=%h busy=%b done=%b cnt=%h ovr=%b part=%b",
                         $time, out_valid, out_data, busy, frame_done, frame_count, err_overrun, err_partial,
                         e_valid, e_data, e_busy, e_done, m_count, m_ovr, m_part);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic capture(input logic [3:0] mask, input logic [63:0] data);
        in_valid = mask;
        in_data  = data;
        step();
        in_valid = '0;
    endtask

    initial begin
        int nb;
        logic [15:0] beats [8];
        rst      = 1'b0;
        in_valid = '0;
        in_data  = '0;
        hold     = 1'b0;
        step();
        step();
        rst = 1'b1;
        #2;
        lit("reset_out_valid", {31'd0, out_valid}, 32'd0);
        lit("reset_busy", {31'd0, busy}, 32'd0);
        lit("reset_out_data", {16'd0, out_data}, 32'd0);
        lit("reset_count", {16'd0, frame_count}, 32'd0);
        lit("reset_errs", {30'd0, err_overrun, err_partial}, 32'd0);

        // 1: plain frame
        capture(4'hF, FRAME_A);
        for (int c = 0; c < 4; c++) begin
            #2;
            lit("t1_valid", {31'd0, out_valid}, 32'd1);
            lit("t1_data", {16'd0, out_data}, 32'(c + 1));
            lit("t1_done", {31'd0, frame_done}, (c == 3) ? 32'd1 : 32'd0);
            step();
        end
        #2;
        lit("t1_count", {16'd0, frame_count}, 32'd1);
        lit("t1_busy", {31'd0, busy}, 32'd0);

        // 2: stalled frame
        capture(4'hF, FRAME_A);
        nb = 0;
        for (int c = 0; c < 6; c++) begin
            hold = (c == 1 || c == 2);
            #2;
            if (c == 1 || c == 2) lit("t2_held_data", {16'd0, out_data}, 32'h2);
            lit("t2_done", {31'd0, frame_done}, (c == 5) ? 32'd1 : 32'd0);
            if (out_valid && nb < 8) begin
                beats[nb] = out_data;
                nb++;
            end
            step();
        end
        hold = 1'b0;
        lit("t2_beats", 32'(nb), 32'd4);
        for (int k = 0; k < 4; k++) lit("t2_order", {16'd0, beats[k]}, 32'(k + 1));
        #2;
        lit("t2_count", {16'd0, frame_count}, 32'd2);

        // 3: back-to-back capture on the final transfer
        step();
        do_reset();
        capture(4'hF, FRAME_A);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                in_valid = 4'hF;
                in_data  = FRAME_B;
            end
            #2;
            lit("t3_data_a", {16'd0, out_data}, 32'(c + 1));
            step();
        end
        in_valid = '0;
        for (int c = 0; c < 4; c++) begin
            #2;
            lit("t3_valid_b", {31'd0, out_valid}, 32'd1);
            lit("t3_data_b", {16'd0, out_data}, 32'(16'h00B1 + c));
            step();
        end
        #2;
        lit("t3_count", {16'd0, frame_count}, 32'd2);
        lit("t3_errs", {30'd0, err_overrun, err_partial}, 32'd0);

        // 4: overrun mid-frame
        do_reset();
        capture(4'hF, FRAME_A);
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                in_valid = 4'hF;
                in_data  = FRAME_B;
            end else begin
                in_valid = '0;
            end
            #2;
            lit("t4_data", {16'd0, out_data}, 32'(c + 1));
            step();
        end
        in_valid = '0;
        #2;
        lit("t4_overrun", {31'd0, err_overrun}, 32'd1);
        lit("t4_count", {16'd0, frame_count}, 32'd1);
        for (int c = 0; c < 4; c++) begin
            step();
            #2;
            lit("t4_dropped", {31'd0, out_valid}, 32'd0);
        end

        // 5: partial capture, then reset mid-replay
        step();
        capture(4'b0111, FRAME_A);
        #2;
        lit("t5_partial", {31'd0, err_partial}, 32'd1);
        lit("t5_overrun_sticky", {31'd0, err_overrun}, 32'd1);
        lit("t5_data0", {16'd0, out_data}, 32'h1);
        step();
        step();
        rst = 1'b0;
        #2;
        lit("t5_no_done", {31'd0, frame_done}, 32'd0);
        step();
        rst = 1'b1;
        #2;
        lit("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        lit("t5_rst_count", {16'd0, frame_count}, 32'd0);
        lit("t5_rst_errs", {30'd0, err_overrun, err_partial}, 32'd0);
        lit("t5_rst_busy", {31'd0, busy}, 32'd0);

        // 6: frame counter wrap
        step();
        force dut.frame_cnt_q = 16'hFFFF;
        m_count = 16'hFFFF;
        step();
        release dut.frame_cnt_q;
        #2;
        lit("t6_preset", {16'd0, frame_count}, 32'hFFFF);
        step();
        capture(4'hF, FRAME_A);
        for (int c = 0; c < 4; c++) begin
            #2;
            lit("t6_done", {31'd0, frame_done}, (c == 3) ? 32'd1 : 32'd0);
            step();
        end
        #2;
        lit("t6_wrap", {16'd0, frame_count}, 32'h0);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
